// File: rtl/kbd_link_pkg.sv
// Shared constants, FSM state type and helpers for the keyboard link controller.
package kbd_link_pkg;

  localparam int FRAME_BITS = 13;
  localparam int ID_BITS    = 3;
  localparam int DATA_BITS  = 10;
  localparam int NGROUPS    = 5;
  localparam int ID_JOY     = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_BIT_LO,
    S_BIT_HI,
    S_TAIL,
    S_GAP
  } state_t;

  // Index of the set bit in a one-hot group vector (0 when empty).
  function automatic logic [ID_BITS-1:0] onehot_to_id(input logic [NGROUPS-1:0] oh);
    logic [ID_BITS-1:0] id;
    id = '0;
    for (int unsigned i = 0; i < NGROUPS; i++) begin
      if (oh[i]) id = ID_BITS'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/kbd_link_ctrl_arb.sv
// 5-way round-robin arbiter: search starts at the group after ptr (the last one granted).
module kbd_rr_arb
  import kbd_link_pkg::*;
(
  input  logic [NGROUPS-1:0] dirty,
  input  logic [ID_BITS-1:0] ptr,
  output logic [NGROUPS-1:0] grant,
  output logic               valid
);

  // First dirty group at or after ptr+1, wrapping modulo NGROUPS.
  always_comb begin
    int unsigned start;
    int unsigned idx;
    grant = '0;
    valid = 1'b0;
    start = (int'(ptr) >= NGROUPS - 1) ? 0 : int'(ptr) + 1;
    for (int unsigned i = 0; i < NGROUPS; i++) begin
      idx = (start + i) % NGROUPS;
      if (!valid && dirty[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kbd_link_ctrl.sv
// Host-side serial keyboard link controller: tracks key/joystick images, picks
// changed groups round-robin and ships each as a 13-bit framed transfer.
module kbd_link_ctrl
  import kbd_link_pkg::*;
#(
  parameter int DIV = 4,
  parameter int GAP = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [39:0]          keys,
  input  logic [4:0]           joy,
  input  logic                 force_req,
  output logic                 kb_clk,
  output logic                 kb_data,
  output logic                 kb_cs,
  output logic                 busy,
  output logic [ID_BITS-1:0]   cur_id,
  output logic                 sent
);

  localparam int CW = $clog2(GAP * DIV) + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP * DIV - 1);
  localparam logic [CW-1:0] GAP_PRE  = CW'(GAP * DIV - 2);

  logic [DATA_BITS-1:0]  grp    [NGROUPS];
  logic [DATA_BITS-1:0]  shadow [NGROUPS];
  logic [NGROUPS-1:0]    pend;
  logic [NGROUPS-1:0]    dirty;
  logic [NGROUPS-1:0]    grant;
  logic                  valid;
  logic [ID_BITS-1:0]    last;
  logic [ID_BITS-1:0]    sel;
  logic                  load;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [3:0]            bits_left;
  logic [FRAME_BITS-1:0] shreg;

  // Split the input images into the five transfer groups.
  always_comb begin
    for (int unsigned g = 0; g < NGROUPS - 1; g++) begin
      grp[g] = keys[DATA_BITS*g +: DATA_BITS];
    end
    grp[ID_JOY] = {5'b0, joy};
  end

  // A group is dirty when pending or when its input differs from what was last sent.
  always_comb begin
    for (int unsigned g = 0; g < NGROUPS; g++) begin
      dirty[g] = pend[g] | (grp[g] != shadow[g]);
    end
  end

  kbd_rr_arb u_arb (
    .dirty (dirty),
    .ptr   (last),
    .grant (grant),
    .valid (valid)
  );

  assign sel  = onehot_to_id(grant);
  assign load = (state == S_IDLE) && valid;

  // Shadow images, pending flags and round-robin pointer; force wins over a same-cycle load clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned g = 0; g < NGROUPS; g++) shadow[g] <= '0;
      pend <= '1;
      last <= ID_BITS'(NGROUPS - 1);
    end else begin
      if (load) begin
        shadow[sel] <= grp[sel];
        pend[sel]   <= 1'b0;
        last        <= sel;
      end
      if (force_req) pend <= '1;
    end
  end

  // Frame sequencer with registered link outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      kb_clk    <= 1'b1;
      kb_cs     <= 1'b1;
      kb_data   <= 1'b0;
      busy      <= 1'b0;
      cur_id    <= '0;
      sent      <= 1'b0;
      cnt       <= '0;
      bits_left <= '0;
      shreg     <= '0;
    end else begin
      sent <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid) begin
            shreg     <= {sel, grp[sel]};
            kb_data   <= sel[ID_BITS-1];
            kb_cs     <= 1'b0;
            busy      <= 1'b1;
            cur_id    <= sel;
            cnt       <= '0;
            bits_left <= 4'(FRAME_BITS - 1);
            state     <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (cnt == DIV_LAST) begin
            cnt    <= '0;
            kb_clk <= 1'b0;
            state  <= S_BIT_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BIT_LO: begin
          if (cnt == DIV_LAST) begin
            cnt    <= '0;
            kb_clk <= 1'b1;
            if (bits_left == '0) begin
              state <= S_TAIL;
            end else begin
              bits_left <= bits_left - 1'b1;
              kb_data   <= shreg[FRAME_BITS-2];
              shreg     <= shreg << 1;
              state     <= S_BIT_HI;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BIT_HI: begin
          if (cnt == DIV_LAST) begin
            cnt    <= '0;
            kb_clk <= 1'b0;
            state  <= S_BIT_LO;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_TAIL: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            kb_cs   <= 1'b1;
            kb_data <= 1'b0;
            state   <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            // Registered, so raising it one cycle early lands it in the last gap cycle.
            if (cnt == GAP_PRE) sent <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_link_ctrl.sv
// Self-checking bench for kbd_link_ctrl: waveform model, wire decoder and directed scenarios.
module tb_kbd_link_ctrl;

  localparam int DIV  = 4;
  localparam int GAP  = 2;
  localparam int LOWW = 27 * DIV;
  localparam int GAPW = GAP * DIV;
  localparam int TOT  = LOWW + GAPW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] keys = '0;
  logic [4:0]  joy = '0;
  logic        force_req = 1'b0;
  logic        kb_clk, kb_data, kb_cs, busy, sent;
  logic [2:0]  cur_id;

  int checks = 0;
  int passed = 0;

  kbd_link_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .keys      (keys),
    .joy       (joy),
    .force_req (force_req),
    .kb_clk    (kb_clk),
    .kb_data   (kb_data),
    .kb_cs     (kb_cs),
    .busy      (busy),
    .cur_id    (cur_id),
    .sent      (sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [9:0]  mshadow [5];
  logic [4:0]  mpend;
  int          mlast, mid, mt;
  bit          mact;
  logic [12:0] mframe;

  function automatic logic [9:0] grp_of(input int g);
    if (g < 4) return keys[10*g +: 10];
    return {5'b0, joy};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 5; g++) mshadow[g] = '0;
      mpend = '1; mlast = 4; mid = 0; mact = 0; mt = 0; mframe = '0;
    end else begin
      if (!mact) begin
        bit found;
        found = 0;
        for (int i = 1; i <= 5; i++) begin
          int g;
          g = (mlast + i) % 5;
          if (!found && (mpend[g] || grp_of(g) != mshadow[g])) begin
            found = 1;
            mframe = {3'(g), grp_of(g)};
            mshadow[g] = grp_of(g);
            mpend[g] = 1'b0;
            mlast = g; mid = g; mact = 1; mt = 0;
          end
        end
      end else if (mt == TOT - 1) begin
        mact = 0;
      end else begin
        mt++;
      end
      if (force_req) mpend = '1;
    end
  end

  // Expected {kb_clk, kb_cs, kb_data, busy, sent, cur_id} from time since frame load.
  function automatic logic [7:0] expected_out();
    logic ec, es, ed, eb, esn;
    int p, k;
    ec = 1; es = 1; ed = 0; eb = 0; esn = 0;
    if (mact) begin
      eb = 1;
      if (mt < LOWW) begin
        p  = mt / DIV;
        es = 0;
        ec = (p % 2 == 1) ? 1'b0 : 1'b1;
        if (p == 0) k = 0;
        else if (p == 26) k = 12;
        else if (p % 2 == 1) k = (p - 1) / 2;
        else k = p / 2;
        ed = mframe[12-k];
      end else begin
        esn = (mt == TOT - 1);
      end
    end
    return {ec, es, ed, eb, esn, 3'(mid)};
  endfunction

  always @(negedge clk) begin
    check("wire", {kb_clk, kb_cs, kb_data, busy, sent, cur_id}, expected_out());
  end

  // ---------------- wire decoder ----------------
  logic [12:0] rx_sh = '0;
  int          rx_n = 0;
  int          rx_id[$];
  int          rx_data[$];

  always @(negedge kb_cs) begin rx_sh = '0; rx_n = 0; end
  always @(negedge kb_clk) if (kb_cs === 1'b0) begin rx_sh = {rx_sh[11:0], kb_data}; rx_n++; end
  always @(posedge kb_cs) begin
    if (rx_n == 13) begin
      rx_id.push_back(int'(rx_sh[12:10]));
      rx_data.push_back(int'(rx_sh[9:0]));
    end
    rx_n = 0;
  end

  int lo_cnt = 0;
  int gp_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      lo_cnt = 0; gp_cnt = 0;
    end else begin
      if (!kb_cs) lo_cnt++;
      else if (lo_cnt > 0) begin check("cs_low_width", lo_cnt, LOWW); lo_cnt = 0; end
      if (kb_cs && busy) gp_cnt++;
      else if (gp_cnt > 0) begin check("gap_width", gp_cnt, GAPW); gp_cnt = 0; end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_rx(input int n, input string name);
    int c;
    c = 0;
    while (rx_id.size() < n && c < n * (TOT + 10) + 50) begin
      @(posedge clk); c++;
    end
    check(name, rx_id.size(), n);
    repeat (GAPW + 4) @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input int id, input int data, input string name);
    if (rx_id.size() == 0) begin
      check({name, "_present"}, 0, 1);
    end else begin
      check({name, "_id"}, rx_id.pop_front(), id);
      check({name, "_data"}, rx_data.pop_front(), data);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {kb_clk, kb_cs, kb_data, busy, sent, cur_id}, 8'b1100_0000);
    @(negedge clk) rst_n = 1'b1;

    // Reset release with zero inputs: ids 0..4, all data 0
    wait_rx(5, "reset_seq_count");
    for (int i = 0; i < 5; i++) expect_frame(i, 0, "reset_seq");
    repeat (20) @(posedge clk);
    #1 check("idle_busy", busy, 0);

    // Single key: keys[7] -> id 0, data 0x080, cs falls one clock later
    keys[7] = 1'b1;
    @(posedge clk); #1;
    check("load_latency_cs", kb_cs, 0);
    wait_rx(1, "single_key_count");
    expect_frame(0, 10'h080, "single_key");

    // Two groups: round-robin after id 0 gives id 1 then id 3
    keys[12] = 1'b1;
    keys[33] = 1'b1;
    wait_rx(2, "two_groups_count");
    expect_frame(1, 10'h004, "rr_first");
    expect_frame(3, 10'h008, "rr_second");

    // Change during a frame: old value first, then resend with the new one
    joy[0] = 1'b1;
    repeat (50) @(posedge clk);
    #1 joy[0] = 1'b0;
    wait_rx(2, "joy_count");
    expect_frame(4, 10'h001, "joy_old");
    expect_frame(4, 10'h000, "joy_new");

    // Force during the id-2 frame: id 2, then 3,4,0,1,2
    keys[25] = 1'b1;
    repeat (30) @(posedge clk);
    #1 force_req = 1'b1;
    @(posedge clk); #1 force_req = 1'b0;
    wait_rx(6, "force_count");
    expect_frame(2, 10'h020, "force_trigger");
    expect_frame(3, 10'h008, "force_g3");
    expect_frame(4, 10'h000, "force_g4");
    expect_frame(0, 10'h080, "force_g0");
    expect_frame(1, 10'h004, "force_g1");
    expect_frame(2, 10'h020, "force_g2");

    // Reset mid-frame at bit 5, then full resync
    keys[1] = 1'b1;
    begin
      int c;
      c = 0;
      while (kb_cs !== 1'b0 && c < 20) begin @(posedge clk); c++; end
      check("mid_frame_start", kb_cs, 0);
    end
    repeat (DIV * (1 + 2 * 5)) @(posedge clk);
    #3 check("mid_frame_clk_low", kb_clk, 0);
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", {kb_clk, kb_cs, kb_data, busy}, 4'b1100);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_rx(5, "resync_count");
    expect_frame(0, 10'h082, "resync_g0");
    expect_frame(1, 10'h004, "resync_g1");
    expect_frame(2, 10'h020, "resync_g2");
    expect_frame(3, 10'h008, "resync_g3");
    expect_frame(4, 10'h000, "resync_g4");

    repeat (15) @(posedge clk);
    #1 check("final_idle", busy, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
